// File: rtl/wall_datapath_if.sv
// wall_datapath_if: controller strobes into the wall datapath and registered pixel bus out to the VGA adapter
interface wall_datapath_if;
   logic       ld_x;
   logic       ld_y;
   logic       ld_alu_out;
   logic       alu_select;
   logic       alu_op;
   logic       writeEn;
   logic       is_color;
   logic [7:0] x_out;
   logic [6:0] y_out;
   logic [2:0] colour_out;
   logic       plot;
   logic       frame_wrap;
   modport master (
      output ld_x, ld_y, ld_alu_out, alu_select, alu_op, writeEn, is_color,
      input  x_out, y_out, colour_out, plot, frame_wrap
   );
   modport slave (
      input  ld_x, ld_y, ld_alu_out, alu_select, alu_op, writeEn, is_color,
      output x_out, y_out, colour_out, plot, frame_wrap
   );
endinterface

// File: rtl/wall_datapath.sv
// wall_datapath: wall column/row address registers, row-step ALU and one registered pixel per cycle
module wall_datapath #(
   parameter logic [7:0] X_BASE      = 8'd0,
   parameter int         NUM_COLS    = 5,
   parameter logic [6:0] Y_MAX       = 7'd119,
   parameter logic [2:0] WALL_COLOUR = 3'b111,
   parameter logic [2:0] BG_COLOUR   = 3'b000
) (
   input logic           clk,
   input logic           resetn,
   wall_datapath_if.slave bus
);
   localparam logic [2:0] LAST_COL = 3'(NUM_COLS - 1);
   logic [7:0] x_reg;
   logic [6:0] y_reg;
   logic [6:0] alu_out;
   logic [6:0] alu_res;
   logic [6:0] alu_nxt;
   logic [2:0] col;
   logic       step;
   logic       advance;
   logic       wrap;
   assign step    = bus.alu_select & bus.ld_alu_out;
   assign advance = bus.ld_x & bus.alu_select & ~bus.ld_alu_out;
   assign wrap    = advance & (col >= LAST_COL);
   // row-step ALU wrapping within 0..Y_MAX; alu_nxt is the value the result register holds after this edge
   always_comb begin
      alu_res = bus.alu_op ? ((y_reg == 7'd0) ? Y_MAX : y_reg - 7'd1)
                           : ((y_reg == Y_MAX) ? 7'd0 : y_reg + 7'd1);
      alu_nxt = bus.ld_alu_out ? alu_res : alu_out;
   end
   // column, row and ALU result registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         x_reg   <= X_BASE;
         y_reg   <= 7'd0;
         alu_out <= 7'd0;
         col     <= 3'd0;
      end else begin
         alu_out <= alu_nxt;
         if (bus.ld_y) y_reg <= step ? alu_nxt : 7'd0;
         if (bus.ld_x) begin
            x_reg <= (!bus.alu_select || wrap) ? X_BASE : bus.ld_alu_out ? x_reg : x_reg + 8'd1;
            col   <= (!bus.alu_select || wrap) ? 3'd0 : bus.ld_alu_out ? col : col + 3'd1;
         end
      end
   end
   // pixel output stage captures the pre-update address every edge; plot alone qualifies it
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         bus.x_out      <= 8'd0;
         bus.y_out      <= 7'd0;
         bus.colour_out <= 3'd0;
         bus.plot       <= 1'b0;
         bus.frame_wrap <= 1'b0;
      end else begin
         bus.x_out      <= x_reg;
         bus.y_out      <= y_reg;
         bus.colour_out <= bus.is_color ? WALL_COLOUR : BG_COLOUR;
         bus.plot       <= bus.writeEn;
         bus.frame_wrap <= wrap;
      end
   end
endmodule

// File: tb/tb_wall_datapath.sv
// tb_wall_datapath: directed stimulus with a behavioural pixel model and literal spot checks
module tb_wall_datapath;
   localparam int XB = 0;
   localparam int NC = 5;
   localparam int YM = 119;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   int checks = 0;
   int errors = 0;
   int m_col, m_y, m_xo, m_yo, m_co, m_pl, m_fw;
   wall_datapath_if bus ();
   wall_datapath dut (.clk(clk), .resetn(resetn), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s actual %0d expected %0d at %0t", n, a, e, $time);
      end
   endtask
   // behavioural model: column index and row number as plain integers, rows modulo Y_MAX+1
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_col <= 0; m_y <= 0; m_xo <= 0; m_yo <= 0; m_co <= 0; m_pl <= 0; m_fw <= 0;
      end else begin
         m_xo <= XB + m_col;
         m_yo <= m_y;
         m_co <= bus.is_color ? 7 : 0;
         m_pl <= int'(bus.writeEn);
         m_fw <= int'(bus.ld_x && bus.alu_select && !bus.ld_alu_out && m_col == NC - 1);
         if (bus.ld_y)
            m_y <= (bus.alu_select && bus.ld_alu_out) ? (bus.alu_op ? (m_y + YM) % (YM + 1) : (m_y + 1) % (YM + 1)) : 0;
         if (bus.ld_x)
            m_col <= !bus.alu_select ? 0 : bus.ld_alu_out ? m_col : (m_col + 1) % NC;
      end
   end
   // compare every cycle against the model
   always @(negedge clk) begin
      chk("x_out", 32'(bus.x_out), 32'(m_xo));
      chk("y_out", 32'(bus.y_out), 32'(m_yo));
      chk("colour_out", 32'(bus.colour_out), 32'(m_co));
      chk("plot", 32'(bus.plot), 32'(m_pl));
      chk("frame_wrap", 32'(bus.frame_wrap), 32'(m_fw));
   end
   // one cycle: apply strobes, take an edge, return on the falling edge with outputs settled
   task automatic cyc(input logic lx, ly, la, as, op, we, ic);
      bus.ld_x = lx; bus.ld_y = ly; bus.ld_alu_out = la; bus.alu_select = as;
      bus.alu_op = op; bus.writeEn = we; bus.is_color = ic;
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic adv();
      cyc(1, 1, 0, 1, 0, 1, 1);
   endtask
   task automatic idle();
      cyc(0, 0, 0, 0, 0, 1, 1);
   endtask
   initial begin
      cyc(0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      resetn = 1'b1;
      // move to column 2, then reset asynchronously mid-cycle while plotting
      adv();
      adv();
      idle();
      chk("pre_reset_x", 32'(bus.x_out), 2);
      chk("pre_reset_plot", 32'(bus.plot), 1);
      @(posedge clk);
      #2 resetn = 1'b0;
      #1;
      chk("async_plot", 32'(bus.plot), 0);
      chk("async_x", 32'(bus.x_out), 0);
      chk("async_y", 32'(bus.y_out), 0);
      @(negedge clk);
      resetn = 1'b1;
      cyc(0, 0, 0, 0, 0, 1, 0);
      chk("post_reset_x", 32'(bus.x_out), XB);
      chk("post_reset_y", 32'(bus.y_out), 0);
      chk("post_reset_plot", 32'(bus.plot), 1);
      // row sweep up through the wrap
      for (int k = 0; k < 121; k++) begin
         cyc(0, 1, 1, 1, 0, 1, 1);
         if (k == 0) chk("sweep_first_y", 32'(bus.y_out), 0);
         if (k == 119) chk("sweep_top_y", 32'(bus.y_out), 119);
      end
      chk("sweep_wrap_y", 32'(bus.y_out), 0);
      chk("sweep_colour", 32'(bus.colour_out), 7);
      // down-step from row 0 wraps to Y_MAX
      cyc(0, 1, 0, 0, 0, 0, 0);
      cyc(0, 1, 1, 1, 1, 1, 1);
      chk("down_from_y", 32'(bus.y_out), 0);
      idle();
      chk("down_wrap_y", 32'(bus.y_out), 119);
      // four advances interleaved with row steps, then the wrapping fifth
      for (int i = 0; i < 4; i++) begin
         cyc(0, 1, 1, 1, 0, 1, 1);
         adv();
         chk("adv_no_wrap", 32'(bus.frame_wrap), 0);
         idle();
         chk("adv_x", 32'(bus.x_out), i + 1);
         chk("adv_y", 32'(bus.y_out), 0);
      end
      adv();
      chk("wrap_pulse", 32'(bus.frame_wrap), 1);
      chk("wrap_pixel_x", 32'(bus.x_out), 4);
      idle();
      chk("wrap_pulse_end", 32'(bus.frame_wrap), 0);
      chk("wrap_x", 32'(bus.x_out), XB);
      // base load at column 3 restarts the column count with no wrap
      adv();
      adv();
      adv();
      cyc(1, 0, 0, 0, 0, 1, 1);
      chk("base_no_wrap", 32'(bus.frame_wrap), 0);
      chk("base_pixel_x", 32'(bus.x_out), 3);
      idle();
      chk("base_x", 32'(bus.x_out), XB);
      for (int i = 0; i < 4; i++) begin
         adv();
         chk("base_adv_no_wrap", 32'(bus.frame_wrap), 0);
      end
      adv();
      chk("base_adv_wrap", 32'(bus.frame_wrap), 1);
      // colour and plot gating
      for (int i = 0; i < 8; i++) begin
         cyc(0, 0, 0, 0, 0, logic'(i % 2 == 0), logic'(i % 2 == 1));
         chk("gate_colour", 32'(bus.colour_out), (i % 2 == 1) ? 7 : 0);
         chk("gate_plot", 32'(bus.plot), (i % 2 == 0) ? 1 : 0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
